// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: queued, pipelined RV32I(+M) instruction decoder.
// Fetch side pushes {instr, pc} into a DEPTH-entry queue (instr_valid_i/instr_ready_o).
// The queue head is decoded combinationally and captured in a registered output
// stage (dec_valid_o/dec_ready_i). A flush empties queue and stage. illegal_cnt_o
// counts illegal instructions handed to execute, saturating at all-ones.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   flush_i                    drop queue and output stage contents
//   instr_valid_i/_ready_o     fetch handshake; instr_i, pc_i payload
//   dec_valid_o/dec_ready_i    execute handshake; dec_pc_o, dec_instr_o payload
//   a_sel_o .. mret_o          decoded control fields
//   illegal_cnt_o              saturating illegal-instruction counter
module decode_stage_pipe #(
    parameter int unsigned DEPTH = 4,
    parameter bit          M_EXT = 1'b1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [31:0]      pc_i,
    output logic             dec_valid_o,
    input  logic             dec_ready_i,
    output logic [31:0]      dec_pc_o,
    output logic [31:0]      dec_instr_o,
    output logic [1:0]       a_sel_o,
    output logic [2:0]       b_sel_o,
    output logic [4:0]       alu_op_o,
    output logic             md_en_o,
    output logic [2:0]       md_op_o,
    output logic [2:0]       csr_op_o,
    output logic             csr_we_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [2:0]       mem_size_o,
    output logic             gpr_we_o,
    output logic [1:0]       wb_sel_o,
    output logic             illegal_instr_o,
    output logic             branch_o,
    output logic             jal_o,
    output logic             jalr_o,
    output logic             mret_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] DepthCnt = DEPTH[PtrW:0];

    typedef struct packed {
        logic [1:0] a_sel;
        logic [2:0] b_sel;
        logic [4:0] alu_op;
        logic       md_en;
        logic [2:0] md_op;
        logic [2:0] csr_op;
        logic       csr_we;
        logic       mem_req;
        logic       mem_we;
        logic [2:0] mem_size;
        logic       gpr_we;
        logic [1:0] wb_sel;
        logic       illegal;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       mret;
    } dec_t;

    // ---------------- instruction queue ----------------
    logic [31:0]     q_instr [DEPTH];
    logic [31:0]     q_pc    [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            full, empty, push, pop;

    assign full          = (count_q == DepthCnt);
    assign empty         = (count_q == '0);
    assign instr_ready_o = !full;
    assign push          = instr_valid_i && !full && !flush_i;
    assign pop           = !empty && (!dec_valid_o || dec_ready_i) && !flush_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_instr[wr_ptr_q] <= instr_i;
            q_pc[wr_ptr_q]    <= pc_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // ---------------- decoder on queue head ----------------
    logic [31:0] head;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ill;
    dec_t        dec_d;

    assign head   = q_instr[rd_ptr_q];
    assign opcode = head[6:0];
    assign f3     = head[14:12];
    assign f7     = head[31:25];

    always_comb begin
        dec_d = '0;
        ill   = 1'b0;
        if (head[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (opcode)
                7'b0000011: begin // LOAD
                    dec_d.mem_req  = 1'b1;
                    dec_d.gpr_we   = 1'b1;
                    dec_d.wb_sel   = 2'd1;
                    dec_d.b_sel    = 3'd1;
                    dec_d.mem_size = f3;
                    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
                end
                7'b0100011: begin // STORE
                    dec_d.mem_req  = 1'b1;
                    dec_d.mem_we   = 1'b1;
                    dec_d.b_sel    = 3'd5;
                    dec_d.mem_size = f3;
                    if (f3 > 3'b010) ill = 1'b1;
                end
                7'b0010011: begin // OP_IMM
                    dec_d.gpr_we = 1'b1;
                    dec_d.b_sel  = 3'd1;
                    dec_d.alu_op = {2'b00, f3};
                    if (f3 == 3'b001 && f7 != 7'b0000000) ill = 1'b1;
                    if (f3 == 3'b101) begin
                        if (f7 == 7'b0100000)      dec_d.alu_op = {2'b01, f3};
                        else if (f7 != 7'b0000000) ill = 1'b1;
                    end
                end
                7'b0110011: begin // OP
                    dec_d.gpr_we = 1'b1;
                    if (f7 == 7'b0000000) begin
                        dec_d.alu_op = {2'b00, f3};
                    end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
                        dec_d.alu_op = {2'b01, f3};
                    end else if (f7 == 7'b0000001 && M_EXT) begin
                        dec_d.md_en = 1'b1;
                        dec_d.md_op = f3;
                    end else begin
                        ill = 1'b1;
                    end
                end
                7'b0110111: begin // LUI
                    dec_d.a_sel  = 2'd2;
                    dec_d.b_sel  = 3'd2;
                    dec_d.gpr_we = 1'b1;
                end
                7'b0010111: begin // AUIPC
                    dec_d.a_sel  = 2'd1;
                    dec_d.b_sel  = 3'd2;
                    dec_d.gpr_we = 1'b1;
                end
                7'b1101111: begin // JAL
                    dec_d.a_sel  = 2'd1;
                    dec_d.b_sel  = 3'd4;
                    dec_d.gpr_we = 1'b1;
                    dec_d.jal    = 1'b1;
                end
                7'b1100111: begin // JALR
                    dec_d.a_sel  = 2'd1;
                    dec_d.b_sel  = 3'd4;
                    dec_d.gpr_we = 1'b1;
                    dec_d.jalr   = 1'b1;
                    if (f3 != 3'b000) ill = 1'b1;
                end
                7'b1100011: begin // BRANCH
                    dec_d.alu_op = {2'b11, f3};
                    dec_d.branch = 1'b1;
                    dec_d.b_sel  = 3'd3;
                    if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
                end
                7'b0001111: begin // MISC_MEM: fence treated as no-op
                end
                7'b1110011: begin // SYSTEM
                    if (head[31:7] == 25'h0604000) begin
                        dec_d.mret = 1'b1;
                    end else if (f3 != 3'b000 && f3 != 3'b100) begin
                        dec_d.csr_op = f3;
                        dec_d.csr_we = 1'b1;
                        dec_d.gpr_we = 1'b1;
                        dec_d.wb_sel = 2'd2;
                    end else begin
                        ill = 1'b1;
                    end
                end
                default: ill = 1'b1;
            endcase
        end
        dec_d.illegal = ill;
        // An illegal instruction must not cause any architectural side effect.
        if (ill) begin
            dec_d.gpr_we  = 1'b0;
            dec_d.csr_we  = 1'b0;
            dec_d.mem_req = 1'b0;
            dec_d.mem_we  = 1'b0;
            dec_d.branch  = 1'b0;
            dec_d.jal     = 1'b0;
            dec_d.jalr    = 1'b0;
            dec_d.mret    = 1'b0;
            dec_d.md_en   = 1'b0;
        end
    end

    // ---------------- registered output stage ----------------
    logic             valid_q;
    dec_t             dec_q;
    logic [31:0]      pc_q, instr_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (pop) begin
            valid_q <= 1'b1;
            dec_q   <= dec_d;
            pc_q    <= q_pc[rd_ptr_q];
            instr_q <= head;
        end else if (dec_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // Counts delivered illegals; a handshake in a flush cycle still delivered one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (valid_q && dec_ready_i && dec_q.illegal && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign dec_valid_o     = valid_q;
    assign dec_pc_o        = pc_q;
    assign dec_instr_o     = instr_q;
    assign a_sel_o         = dec_q.a_sel;
    assign b_sel_o         = dec_q.b_sel;
    assign alu_op_o        = dec_q.alu_op;
    assign md_en_o         = dec_q.md_en;
    assign md_op_o         = dec_q.md_op;
    assign csr_op_o        = dec_q.csr_op;
    assign csr_we_o        = dec_q.csr_we;
    assign mem_req_o       = dec_q.mem_req;
    assign mem_we_o        = dec_q.mem_we;
    assign mem_size_o      = dec_q.mem_size;
    assign gpr_we_o        = dec_q.gpr_we;
    assign wb_sel_o        = dec_q.wb_sel;
    assign illegal_instr_o = dec_q.illegal;
    assign branch_o        = dec_q.branch;
    assign jal_o           = dec_q.jal;
    assign jalr_o          = dec_q.jalr;
    assign mret_o          = dec_q.mret;
    assign illegal_cnt_o   = cnt_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed, table-driven bench for decode_stage_pipe. A second instance with
// M_EXT=0 shares all inputs and checks that M-extension encodings become illegal.
module tb_decode_stage_pipe;

    typedef struct packed {
        logic [1:0] a_sel;
        logic [2:0] b_sel;
        logic [4:0] alu_op;
        logic       md_en;
        logic [2:0] md_op;
        logic [2:0] csr_op;
        logic       csr_we;
        logic       mem_req;
        logic       mem_we;
        logic [2:0] mem_size;
        logic       gpr_we;
        logic [1:0] wb_sel;
        logic       illegal;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       mret;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        exp_t        e;
        logic        ill0;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        instr_valid = 1'b0;
    logic        dec_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;

    logic        instr_ready, dec_valid;
    logic [31:0] dec_pc, dec_instr;
    logic [1:0]  a_sel, wb_sel;
    logic [2:0]  b_sel, md_op, csr_op, mem_size;
    logic [4:0]  alu_op;
    logic        md_en, csr_we, mem_req, mem_we, gpr_we, illegal, branch, jal, jalr, mret;
    logic [7:0]  cnt;

    logic        m0_ready, m0_valid;
    logic [31:0] m0_pc, m0_instr;
    logic [1:0]  m0_a_sel, m0_wb_sel;
    logic [2:0]  m0_b_sel, m0_md_op, m0_csr_op, m0_mem_size;
    logic [4:0]  m0_alu_op;
    logic        m0_md_en, m0_csr_we, m0_mem_req, m0_mem_we, m0_gpr_we, m0_illegal;
    logic        m0_branch, m0_jal, m0_jalr, m0_mret;
    logic [7:0]  m0_cnt;

    always #5 clk = ~clk;

    decode_stage_pipe #(.DEPTH(4), .M_EXT(1'b1), .CNT_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .instr_i(instr), .pc_i(pc),
        .dec_valid_o(dec_valid), .dec_ready_i(dec_ready),
        .dec_pc_o(dec_pc), .dec_instr_o(dec_instr),
        .a_sel_o(a_sel), .b_sel_o(b_sel), .alu_op_o(alu_op),
        .md_en_o(md_en), .md_op_o(md_op), .csr_op_o(csr_op), .csr_we_o(csr_we),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_size_o(mem_size),
        .gpr_we_o(gpr_we), .wb_sel_o(wb_sel), .illegal_instr_o(illegal),
        .branch_o(branch), .jal_o(jal), .jalr_o(jalr), .mret_o(mret),
        .illegal_cnt_o(cnt)
    );

    decode_stage_pipe #(.DEPTH(4), .M_EXT(1'b0), .CNT_W(8)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .instr_valid_i(instr_valid), .instr_ready_o(m0_ready),
        .instr_i(instr), .pc_i(pc),
        .dec_valid_o(m0_valid), .dec_ready_i(dec_ready),
        .dec_pc_o(m0_pc), .dec_instr_o(m0_instr),
        .a_sel_o(m0_a_sel), .b_sel_o(m0_b_sel), .alu_op_o(m0_alu_op),
        .md_en_o(m0_md_en), .md_op_o(m0_md_op), .csr_op_o(m0_csr_op), .csr_we_o(m0_csr_we),
        .mem_req_o(m0_mem_req), .mem_we_o(m0_mem_we), .mem_size_o(m0_mem_size),
        .gpr_we_o(m0_gpr_we), .wb_sel_o(m0_wb_sel), .illegal_instr_o(m0_illegal),
        .branch_o(m0_branch), .jal_o(m0_jal), .jalr_o(m0_jalr), .mret_o(m0_mret),
        .illegal_cnt_o(m0_cnt)
    );

    exp_t act;
    assign act = {a_sel, b_sel, alu_op, md_en, md_op, csr_op, csr_we, mem_req, mem_we,
                  mem_size, gpr_we, wb_sel, illegal, branch, jal, jalr, mret};

    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[$];
    exp_t        e;
    logic [31:0] w [5];
    int          exp_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic add(input logic [31:0] i, input exp_t x, input logic ill0);
        vec_t v;
        v.instr = i;
        v.e     = x;
        v.ill0  = ill0;
        vecs.push_back(v);
    endtask

    // Waits at negedges for dec_valid; n is the number of extra negedges waited.
    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!dec_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!dec_valid) check({name, " timeout"}, 64'(dec_valid), 64'd1);
    endtask

    // Pushes w[0..4] on consecutive cycles, checking acceptance each time.
    task automatic fill(input string name);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("%s rdy%0d", name, k), 64'(instr_ready), 64'd1);
            instr_valid = 1'b1;
            instr       = w[k];
            pc          = 32'h2000 + 32'(k * 4);
        end
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    initial begin
        int n;
        for (int k = 0; k < 5; k++) w[k] = 32'h0000_0093 | (32'(k + 1) << 20);

        e = '0; e.gpr_we = 1; e.b_sel = 3'd1;                          add(32'h00500093, e, 0);
        e = '0; e.gpr_we = 1; e.alu_op = 5'b01000;                     add(32'h40208033, e, 0);
        e = '0; e.gpr_we = 1; e.md_en = 1; e.md_op = 3'd0;             add(32'h02208033, e, 1);
        e = '0; e.illegal = 1;                                          add(32'hFFFFFFFF, e, 1);
        e = '0; e.illegal = 1;                                          add(32'h00000073, e, 1);
        e = '0; e.illegal = 1;                                          add(32'h00003003, e, 1);
        e = '0; e.mret = 1;                                             add(32'h30200073, e, 0);
        e = '0; e.csr_op = 3'd1; e.csr_we = 1; e.gpr_we = 1; e.wb_sel = 2'd2;
                                                                        add(32'h34029073, e, 0);
        e = '0; e.mem_req = 1; e.gpr_we = 1; e.wb_sel = 2'd1; e.b_sel = 3'd1; e.mem_size = 3'd2;
                                                                        add(32'h0000A083, e, 0);
        e = '0; e.mem_req = 1; e.mem_we = 1; e.b_sel = 3'd5; e.mem_size = 3'd2;
                                                                        add(32'h0020A023, e, 0);
        e = '0; e.alu_op = 5'b11000; e.branch = 1; e.b_sel = 3'd3;     add(32'h00208063, e, 0);
        e = '0; e.a_sel = 2'd1; e.b_sel = 3'd4; e.gpr_we = 1; e.jal = 1;  add(32'h0000006F, e, 0);
        e = '0; e.a_sel = 2'd1; e.b_sel = 3'd4; e.gpr_we = 1; e.jalr = 1; add(32'h00008067, e, 0);
        e = '0; e.a_sel = 2'd2; e.b_sel = 3'd2; e.gpr_we = 1;           add(32'h000010B7, e, 0);
        e = '0; e.a_sel = 2'd1; e.b_sel = 3'd2; e.gpr_we = 1;           add(32'h00000097, e, 0);
        e = '0; e.gpr_we = 1; e.b_sel = 3'd1; e.alu_op = 5'b01101;      add(32'h4010D093, e, 0);
        e = '0; e.illegal = 1;                                          add(32'h40109093, e, 1);
        e = '0; e.illegal = 1;                                          add(32'h00002063, e, 1);
        e = '0;                                                         add(32'h0000000F, e, 0);
        e = '0; e.illegal = 1;                                          add(32'h00000001, e, 1);
        e = '0; e.gpr_we = 1; e.md_en = 1; e.md_op = 3'd5;             add(32'h0220D0B3, e, 1);

        // Reset state (still in reset, then first cycle after release).
        repeat (2) @(negedge clk);
        check("rst valid", 64'(dec_valid), 64'd0);
        check("rst decode", 64'(act), 64'd0);
        check("rst cnt", 64'(cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst ready", 64'(instr_ready), 64'd1);

        // Table: one instruction at a time with execute always ready.
        foreach (vecs[i]) begin
            @(negedge clk);
            instr_valid = 1'b1;
            instr       = vecs[i].instr;
            pc          = 32'h1000 + 32'(i * 4);
            dec_ready   = 1'b1;
            @(negedge clk);
            instr_valid = 1'b0;
            check($sformatf("v%0d early", i), 64'(dec_valid), 64'd0);
            wait_valid($sformatf("v%0d", i), n);
            check($sformatf("v%0d latency", i), 64'(n), 64'd1);
            if (vecs[i].e.illegal)
                check($sformatf("v%0d illegal-en", i),
                      64'({md_en, csr_we, mem_req, mem_we, gpr_we, illegal, branch, jal, jalr, mret}),
                      64'({vecs[i].e.md_en, vecs[i].e.csr_we, vecs[i].e.mem_req, vecs[i].e.mem_we,
                           vecs[i].e.gpr_we, vecs[i].e.illegal, vecs[i].e.branch, vecs[i].e.jal,
                           vecs[i].e.jalr, vecs[i].e.mret}));
            else
                check($sformatf("v%0d decode", i), 64'(act), 64'(vecs[i].e));
            check($sformatf("v%0d pc", i), 64'(dec_pc), 64'(32'h1000 + 32'(i * 4)));
            check($sformatf("v%0d instr", i), 64'(dec_instr), 64'(vecs[i].instr));
            check($sformatf("v%0d m0", i), 64'({m0_illegal, m0_gpr_we, m0_md_en}),
                  64'({vecs[i].ill0, vecs[i].e.gpr_we & ~vecs[i].ill0, 1'b0}));
            if (vecs[i].e.illegal) exp_cnt++;
            @(negedge clk);
            check($sformatf("v%0d drained", i), 64'(dec_valid), 64'd0);
            check($sformatf("v%0d cnt", i), 64'(cnt), 64'(exp_cnt));
        end

        // Back-pressure: 4 queued plus 1 in the stage, outputs frozen, then 1/cycle drain.
        dec_ready = 1'b0;
        fill("stall");
        check("stall full", 64'(instr_ready), 64'd0);
        check("stall valid", 64'(dec_valid), 64'd1);
        check("stall head", 64'(dec_instr), 64'(w[0]));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall hold%0d", k), 64'({dec_valid, dec_instr, dec_pc}),
                  64'({1'b1, w[0], 32'h2000}));
        end
        dec_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("drain%0d", k), 64'({dec_valid, dec_instr}), 64'({1'b1, w[k]}));
        end
        @(negedge clk);
        check("drain empty", 64'(dec_valid), 64'd0);

        // Flush with a full queue and a simultaneous push attempt.
        dec_ready = 1'b0;
        fill("flush");
        flush       = 1'b1;
        instr_valid = 1'b1;
        instr       = 32'h0AB00093;
        @(negedge clk);
        flush       = 1'b0;
        instr_valid = 1'b0;
        check("flush valid", 64'(dec_valid), 64'd0);
        check("flush ready", 64'(instr_ready), 64'd1);

        // Flush with a non-full queue: the same-cycle push must be discarded.
        instr_valid = 1'b1;
        instr       = w[0];
        @(negedge clk);
        flush = 1'b1;
        instr = 32'h0AB00093;
        @(negedge clk);
        flush     = 1'b0;
        instr     = w[2];
        dec_ready = 1'b1;
        check("flush2 valid", 64'(dec_valid), 64'd0);
        check("flush2 ready", 64'(instr_ready), 64'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        wait_valid("flush2", n);
        check("flush2 latency", 64'(n), 64'd1);
        check("flush2 first", 64'(dec_instr), 64'(w[2]));
        @(negedge clk);
        check("flush2 empty", 64'(dec_valid), 64'd0);
        check("flush cnt kept", 64'(cnt), 64'(exp_cnt));

        // Saturation: stream 260 illegal words.
        instr       = 32'hFFFFFFFF;
        instr_valid = 1'b1;
        repeat (260) @(negedge clk);
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("sat valid", 64'(dec_valid), 64'd0);
        check("sat cnt", 64'(cnt), 64'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
